// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and the 12-bit colour layout.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int PIX_LAT_DEF  = 1;
    localparam int CW_DEF       = 10;

    localparam int RGB_W = 12;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

endpackage

// File: rtl/sync_delay.sv
// Reset-cleared shift register that lines the timing flags up with the pixel source.
// A DEPTH of zero turns it into a plain wire.
module sync_delay #(
    parameter int W     = 3,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unusedOk;
        assign unusedOk = clk_i ^ rst_ni;
        assign q_o      = d_i;
    end else begin : g_shift
        logic [W-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/visible decode and the registered colour/sync output stage.
// Sync flags are carried active-high internally; polarity is applied only at the output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = PIX_LAT_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CW-1:0]    pix_x,
    output logic [CW-1:0]    pix_y,
    output logic             pix_req,
    output logic             line_start,
    output logic             frame_start,
    output logic [3:0]       red_out,
    output logic [3:0]       green_out,
    output logic [3:0]       blue_out,
    output logic             hsync,
    output logic             vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hCount_q, hCount_d;
    logic [CW-1:0] vCount_q, vCount_d;
    logic          pixReq, hsRaw, vsRaw;
    logic          deDly, hsDly, vsDly;
    rgb_t          colour_q;
    logic          hsync_q, vsync_q;

    // The line counter only moves on the last pixel of a line, so vsync
    // changes together with the horizontal wrap.
    always_comb begin
        hCount_d = hCount_q + CW'(1);
        vCount_d = vCount_q;
        if (hCount_q == H_LAST) begin
            hCount_d = '0;
            vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + CW'(1);
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            hCount_q <= '0;
            vCount_q <= '0;
        end else begin
            hCount_q <= hCount_d;
            vCount_q <= vCount_d;
        end
    end

    assign pixReq = (hCount_q < H_VIS) && (vCount_q < V_VIS);
    assign hsRaw  = (hCount_q >= HS_START) && (hCount_q < HS_END);
    assign vsRaw  = (vCount_q >= VS_START) && (vCount_q < VS_END);

    assign pix_x       = hCount_q;
    assign pix_y       = vCount_q;
    assign pix_req     = pixReq;
    assign line_start  = (hCount_q == '0);
    assign frame_start = (hCount_q == '0) && (vCount_q == '0);

    sync_delay #(
        .W     (3),
        .DEPTH (PIX_LAT)
    ) u_sync_delay (
        .clk_i  (clk25),
        .rst_ni (rst_n),
        .d_i    ({pixReq, hsRaw, vsRaw}),
        .q_o    ({deDly, hsDly, vsDly})
    );

    // Colour is forced to zero whenever the delayed enable says the pixel is off-screen.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            colour_q <= '0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
        end else begin
            colour_q <= deDly ? rgb_t'(rgb_in) : '0;
            hsync_q  <= hsDly ? HS_POL : ~HS_POL;
            vsync_q  <= vsDly ? VS_POL : ~VS_POL;
        end
    end

    assign red_out   = colour_q.red;
    assign green_out = colour_q.green;
    assign blue_out  = colour_q.blue;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

endmodule
